// File: rtl/sharpen_row_filter.sv
// Horizontal [-1,3,-1] row sharpener on an 8-bit pixel field, with edge replication and a single output slot.
// Optional clamp counter (sat_cnt) enabled by defining SHARPEN_SAT_CNT_EN.
module sharpen_row_filter #(
  parameter int ROW_LEN   = 64,
  parameter int FIELD_LSB = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mask_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last
`ifdef SHARPEN_SAT_CNT_EN
  ,
  output logic [15:0] sat_cnt
`endif
);

  localparam int CW = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(ROW_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [7:0]      cur_q, cur_d, prev_q, prev_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            out_last_q, out_last_d;

  logic            slot_free, accept, emit;
  logic [7:0]      pix, r_pix, y_clamped;
  logic signed [10:0] y;
  logic            sat_lo, sat_hi;
  logic [31:0]     emit_data;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q != FLUSH) && slot_free;
  assign accept    = in_valid && in_ready;
  assign pix       = 8'((in_data & mask_in) >> FIELD_LSB);

  // Right neighbour is the incoming pixel, except on the row's last pixel where it replicates itself.
  assign r_pix = (state_q == FLUSH) ? cur_q : pix;

  always_comb begin
    y = $signed({3'b000, cur_q}) + $signed({3'b000, cur_q}) + $signed({3'b000, cur_q})
      - $signed({3'b000, prev_q}) - $signed({3'b000, r_pix});
    sat_lo = y[10];
    sat_hi = !y[10] && (y[9:8] != 2'b00);
    if (sat_lo)      y_clamped = 8'h00;
    else if (sat_hi) y_clamped = 8'hFF;
    else             y_clamped = y[7:0];
    emit_data = (32'(y_clamped) << FIELD_LSB) & mask_in;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    emit        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_d   = pix;
          prev_d  = pix;
          col_d   = CW'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          emit   = 1'b1;
          prev_d = cur_q;
          cur_d  = pix;
          if (col_q == LAST_COL) begin
            state_d = FLUSH;
            col_d   = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_data;
      out_last_d  = (state_q == FLUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      col_q       <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

`ifdef SHARPEN_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counted when the result is produced, independent of when downstream takes it.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (emit && (sat_lo || sat_hi) && (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_sharpen_row_filter.sv
// Scoreboard bench for sharpen_row_filter: directed rows, backpressure, mid-row reset, then random traffic.
module tb_sharpen_row_filter;
  localparam int ROW_LEN = 4;
  localparam int FL      = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mask_in = 32'h000FF000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
`ifdef SHARPEN_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  sharpen_row_filter #(.ROW_LEN(ROW_LEN), .FIELD_LSB(FL)) dut (
    .clk(clk), .reset(reset), .mask_in(mask_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef SHARPEN_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    bit          sat;
  } exp_t;

  exp_t sb[$];
  int   row[$];
  int   compared = 0;
  int   mismatched = 0;
  int   sat_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer kernel, clamp, and placement into bits 19:12.
  function automatic exp_t model(input int l, input int c, input int r, input bit last);
    exp_t e;
    int   y;
    y     = 3 * c - l - r;
    e.sat = (y < 0) || (y > 255);
    if (y < 0)   y = 0;
    if (y > 255) y = 255;
    e.data = 32'(y) << FL;
    e.last = last;
    return e;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge.
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;
  bit          flush_chk = 0;
  bit          rst_prev = 0;
  exp_t        mon_e;
  int          k;

  always @(negedge clk) begin
    if (rst_prev) begin
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("reset_out_last", 32'(out_last), 32'd0);
    end
    if (flush_chk) begin
      check("flush_in_ready", 32'(in_ready), 32'd0);
      flush_chk = 0;
    end
    if (hold_v && out_valid) begin
      check("stall_data_stable", out_data, hold_d);
      check("stall_last_stable", 32'(out_last), 32'(hold_l));
    end
    if (out_valid && !out_ready && !reset) check("stall_in_ready", 32'(in_ready), 32'd0);
    hold_v = out_valid && !out_ready && !reset;
    hold_d = out_data;
    hold_l = out_last;

    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got %h with nothing expected at %0t", out_data, $time);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_last", 32'(out_last), 32'(mon_e.last));
        if (mon_e.sat) sat_model++;
      end
    end

    if (reset) begin
      sb.delete();
      row.delete();
      flush_chk = 0;
      sat_model = 0;
    end else if (in_valid && in_ready) begin
      row.push_back(int'(in_data[FL +: 8]));
      k = row.size() - 1;
      if (k >= 1)
        sb.push_back(model(row[(k == 1) ? 0 : k - 2], row[k - 1], row[k], 1'b0));
      if (k == ROW_LEN - 1) begin
        sb.push_back(model(row[k - 1], row[k], row[k], 1'b1));
        row.delete();
        flush_chk = 1;
      end
    end
    rst_prev = reset;
  end

  task automatic send(input logic [31:0] w);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_row(input int a, input int b, input int c, input int d);
    send(32'(a) << FL);
    send(32'(b) << FL);
    send(32'(c) << FL);
    send(32'(d) << FL);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    send_row(10, 20, 30, 40);
    idle(3);
    send_row(0, 255, 0, 0);
    idle(3);
    repeat (ROW_LEN) send(32'hABC7F123);
    idle(3);

    fork
      send_row(10, 20, 30, 40);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);

    send(32'(10) << FL);
    send(32'(20) << FL);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send_row(10, 20, 30, 40);
    idle(3);

    send_row(10, 20, 30, 40);
    send_row(200, 5, 90, 255);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    idle(10);

    check("drain_queue_empty", 32'(sb.size()), 32'd0);
`ifdef SHARPEN_SAT_CNT_EN
    check("sat_cnt", 32'(sat_cnt), 32'(sat_model));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sharpen_row_filter.md
Name: sharpen_row_filter

Overview:
Streaming horizontal sharpening stage for the image-sharpening datapath.
- Takes 32-bit words carrying an 8-bit pixel in the field selected by a constant mask input. That input is driven by the 32'h000FF000 mask constant block.
- Applies kernel [-1, 3, -1] along each row with edge replication, clamps the result to 0..255, and re-packs it into the same field.
- Sits between the pixel fetch path and the DLX write-back/store path.

Parameters:
ROW_LEN, 64, pixels per row; legal range >= 2.
FIELD_LSB, 12, bit position of the pixel LSB inside the 32-bit word.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous reset, active-high
mask_in  in  32  pixel-field mask; tied to 32'h000FF000
in_valid  in  1  input word valid
in_ready  out  1  stage accepts input this cycle
in_data  in  32  input word; pixel = (in_data & mask_in) >> FIELD_LSB
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output
out_data  out  32  ((clamped pixel) << FIELD_LSB) & mask_in; all other bits zero
out_last  out  1  high with the output word of the row's last pixel

Behaviour:
- Reset (synchronous, active-high; clk, reset):
  - out_valid=0, out_data=0, out_last=0.
  - Column counter col=0; cur=0, prev=0; state=IDLE.
  - Reset mid-row discards all partial row state. No output for discarded pixels.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
- Output slot: single registered slot. slot_free = !out_valid || out_ready.
- in_ready = (state != FLUSH) && slot_free. It is combinational from out_ready only.
- Pixel math:
  - y = 3*cur - l - r in 11-bit signed (range -510..765).
  - y < 0 -> 0; y > 255 -> 255; otherwise y[7:0].
- States:
  - IDLE (expecting col 0). On accept: cur=p, prev=p (left edge replicate), col=1, go RUN. No output produced.
  - RUN. On accept of p:
    - Emit cur with l=prev, r=p, out_last=0.
    - Then prev=cur, cur=p.
    - If col==ROW_LEN-1: go FLUSH, col=0. Else col=col+1.
  - FLUSH. When slot_free:
    - Emit cur with l=prev, r=cur (right edge replicate), out_last=1.
    - Go IDLE.
    - in_ready=0 for the whole time in FLUSH.
- Latency:
  - Pixel i (i < ROW_LEN-1) appears on out_data one cycle after pixel i+1 is accepted.
  - The last pixel appears one cycle after entering FLUSH, if slot_free.
- Throughput:
  - With out_ready held high, one word per cycle.
  - One bubble per row (the FLUSH cycle).
- When out_valid is set and out_ready is low, nothing advances.
- mask_in is treated as static. Bits outside the field in in_data are ignored.

Optional Feature:
Macro SHARPEN_SAT_CNT_EN.
- Defined:
  - Adds output port sat_cnt[15:0], reset to 0.
  - Increments by 1 on each emitted output whose y was clamped (y<0 or y>255).
  - Counts at emit time, not transfer time.
  - Saturates at 16'hFFFF; does not wrap.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
1. ROW_LEN=4, out_ready=1, pixels 10,20,30,40 in field 19:12 -> out_data 0x00000000, 0x00014000, 0x0001E000, 0x00032000 (0,20,30,50); out_last only on the 4th; in_ready=0 for exactly one cycle after the 4th accept.
2. ROW_LEN=4, pixels 0,255,0,0 -> outputs 0,255,0,0; with SHARPEN_SAT_CNT_EN, sat_cnt=3 (p3 y=0 not counted).
3. in_data=0xABC7F123 repeated for a full row -> every out_data=0x0007F000 (garbage bits stripped, flat row passes unchanged).
4. Backpressure: hold out_ready=0 for 3 cycles mid-row -> out_data/out_valid stable, in_ready=0, no input lost; resuming gives the identical sequence as case 1.
5. Assert reset for 1 cycle after 2 pixels of a row -> out_valid=0 next cycle; the next accepted pixel is treated as col 0; the following 4-pixel row reproduces case 1 exactly.
6. Two back-to-back rows of 4 with in_valid held high -> 8 outputs, out_last on the 4th and 8th; the first output of row 2 uses left-edge replicate, with no dependence on row 1.
